nbit_universal_shift_register: RTL

- Parametrised successor to the team's fixed 8-bit D flip-flop register.
- Provides WIDTH-bit storage with synchronous reset and preset, parallel load, hold, shift, rotate and an auto-serialise mode.
- Serialise mode is a small FSM that loads a word, shifts it out LSB-first over WIDTH cycles, then pulses done.
- Used as a general register, shifter or parallel-to-serial converter in datapath and I/O blocks.

---
 rtl/usr_pkg.sv | 19 +
 rtl/nbit_universal_shift_register_if.sv | 28 ++
 rtl/usr_next_value.sv | 27 ++
 rtl/nbit_universal_shift_register.sv | 79 +++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared constants for the universal shift register: operation codes and the
// encoding of the two-state serialise controller.
package usr_pkg;

   localparam int MODE_W = 3;

   localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
   localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
   localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
   localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
   localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
   localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
   localparam logic [MODE_W-1:0] MODE_SER  = 3'b110;
   localparam logic [MODE_W-1:0] MODE_RSVD = 3'b111;

   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_SHIFTING = 1'b1;

endpackage

// File: rtl/nbit_universal_shift_register_if.sv
// Control/data bundle of the universal shift register; the master drives
// operation requests, the slave (the register) returns contents and status.
interface nbit_universal_shift_register_if #(
   parameter int WIDTH = 8
);
   import usr_pkg::*;

   logic              preset;
   logic [MODE_W-1:0] mode;
   logic [WIDTH-1:0]  d;
   logic              serial_in;
   logic [WIDTH-1:0]  q;
   logic [WIDTH-1:0]  q_bar;
   logic              ser_out;
   logic              busy;
   logic              done;

   modport master (
      output preset, mode, d, serial_in,
      input  q, q_bar, ser_out, busy, done
   );

   modport slave (
      input  preset, mode, d, serial_in,
      output q, q_bar, ser_out, busy, done
   );

endinterface

// File: rtl/usr_next_value.sv
// Combinational next-contents selector: picks load, shift or rotate of the
// current word according to the operation code.
module usr_next_value
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]  q,
   input  logic [WIDTH-1:0]  d,
   input  logic              serial_in,
   output logic [WIDTH-1:0]  q_next
);

   always_comb begin
      q_next = q;
      case (mode)
         MODE_LOAD, MODE_SER: q_next = d;
         MODE_SHL:            q_next = {q[WIDTH-2:0], serial_in};
         MODE_SHR:            q_next = {serial_in, q[WIDTH-1:1]};
         MODE_ROL:            q_next = {q[WIDTH-2:0], q[WIDTH-1]};
         MODE_ROR:            q_next = {q[0], q[WIDTH-1:1]};
         default:             q_next = q;
      endcase
   end

endmodule

// File: rtl/nbit_universal_shift_register.sv
// WIDTH-bit register with load/shift/rotate and an automatic LSB-first
// serialiser that pulses done once the whole word has been shifted out.
module nbit_universal_shift_register
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input logic                            clk,
   input logic                            rst,
   nbit_universal_shift_register_if.slave bus
);

   generate
      if (WIDTH < 2) begin : g_width_check
         $error("nbit_universal_shift_register: WIDTH must be 2 or more");
      end
   endgenerate

   logic [WIDTH-1:0]  q_reg, q_next;
   logic [0:0]        state_reg, state_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic              done_reg, done_next;
   logic [MODE_W-1:0] eff_mode;

   // While serialising the datapath is forced into a plain right shift,
   // so the user's mode code has no effect until the controller is idle.
   assign eff_mode = (state_reg == ST_SHIFTING) ? MODE_SHR : bus.mode;

   usr_next_value #(
      .WIDTH (WIDTH)
   ) u_next_value (
      .mode      (eff_mode),
      .q         (q_reg),
      .d         (bus.d),
      .serial_in (bus.serial_in),
      .q_next    (q_next)
   );

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      done_next  = 1'b0;
      if (!bus.preset) begin
         state_next = ST_IDLE;
         count_next = '0;
      end else if (state_reg == ST_SHIFTING) begin
         count_next = count_reg - CNT_W'(1);
         if (count_reg == CNT_W'(1)) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
         end
      end else if (bus.mode == MODE_SER) begin
         state_next = ST_SHIFTING;
         count_next = CNT_W'(WIDTH);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         q_reg     <= '0;
         state_reg <= ST_IDLE;
         count_reg <= '0;
         done_reg  <= 1'b0;
      end else begin
         q_reg     <= bus.preset ? q_next : {WIDTH{1'b1}};
         state_reg <= state_next;
         count_reg <= count_next;
         done_reg  <= done_next;
      end
   end

   assign bus.q       = q_reg;
   assign bus.q_bar   = ~q_reg;
   assign bus.ser_out = q_reg[0];
   assign bus.busy    = (state_reg == ST_SHIFTING);
   assign bus.done    = done_reg;

endmodule
